// File: rtl/stack_pkg.sv
// Shared types for the hardware-stack sequencer:
// operation codes, FSM states and default widths.
package stack_pkg;

  localparam int DATA_W_DEF    = 10;
  localparam int STACK_MAX_DEF = 256;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_PUSH = 3'b001,
    OP_POP  = 3'b010,
    OP_LDSP = 3'b011,
    OP_CLR  = 3'b100
  } op_e;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_CAP  = 3'd4,
    ST_LD   = 3'd5,
    ST_CLR  = 3'd6
  } state_e;

endpackage

// File: rtl/stack_ctrl_if.sv
// Bundle between the control unit, the stack sequencer
// and the SP register / scratch-RAM pair.
interface stack_ctrl_if
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              op_valid;
  logic [2:0]        op_code;
  logic [DATA_W-1:0] op_data;
  logic              op_ready;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic [7:0]        sp_in;
  logic [7:0]        sp_data;
  logic              sp_rst;
  logic              sp_ld;
  logic              sp_incr;
  logic              sp_decr;
  logic [7:0]        scr_addr;
  logic              scr_we;
  logic [DATA_W-1:0] scr_wdata;
  logic [DATA_W-1:0] scr_rdata;
  logic              err;
  logic              ovf;
  logic              unf;

  modport master (
    output op_valid, op_code, op_data,
    output sp_in, scr_rdata,
    input  op_ready, pop_data, pop_valid,
    input  sp_data, sp_rst, sp_ld,
    input  sp_incr, sp_decr,
    input  scr_addr, scr_we, scr_wdata,
    input  err, ovf, unf
  );

  modport slave (
    input  op_valid, op_code, op_data,
    input  sp_in, scr_rdata,
    output op_ready, pop_data, pop_valid,
    output sp_data, sp_rst, sp_ld,
    output sp_incr, sp_decr,
    output scr_addr, scr_we, scr_wdata,
    output err, ovf, unf
  );

endinterface

// File: rtl/stack_ctrl.sv
// Hardware-stack sequencer: one op at a time, drives SP
// strobes and scratch-RAM access, tracks occupancy.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int STACK_MAX = STACK_MAX_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  stack_ctrl_if.slave bus
);

  localparam logic [2:0] S_INIT = ST_INIT;
  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_WR   = ST_WR;
  localparam logic [2:0] S_RD   = ST_RD;
  localparam logic [2:0] S_CAP  = ST_CAP;
  localparam logic [2:0] S_LD   = ST_LD;
  localparam logic [2:0] S_CLR  = ST_CLR;

  localparam logic [8:0] CNT_MAX = 9'(STACK_MAX);

  logic [2:0]        r_state;
  logic [8:0]        r_cnt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_pop_data;
  logic              r_pop_valid;
  logic              r_err;
  logic              r_ovf;
  logic              r_unf;

  logic [2:0] w_next;
  logic       w_idle;
  logic       w_acc;
  logic       w_push;
  logic       w_pop;
  logic       w_ldsp;
  logic       w_clr;
  logic       w_ovf_hit;
  logic       w_unf_hit;
  logic [7:0] w_addr;

  assign w_idle = (r_state == S_IDLE);
  assign w_acc  = bus.op_valid && w_idle;
  assign w_push = (bus.op_code == OP_PUSH);
  assign w_pop  = (bus.op_code == OP_POP);
  assign w_ldsp = (bus.op_code == OP_LDSP);
  assign w_clr  = (bus.op_code == OP_CLR);

  always_comb begin
    w_next    = r_state;
    w_ovf_hit = 1'b0;
    w_unf_hit = 1'b0;
    unique case (r_state)
      S_INIT: w_next = S_IDLE;
      S_IDLE: begin
        if (w_acc) begin
          unique case (1'b1)
            w_push: begin
              if (r_cnt == CNT_MAX) w_ovf_hit = 1'b1;
              else                  w_next    = S_WR;
            end
            w_pop: begin
              if (r_cnt == 9'd0) w_unf_hit = 1'b1;
              else               w_next    = S_RD;
            end
            w_ldsp:  w_next = S_LD;
            w_clr:   w_next = S_CLR;
            default: w_next = S_IDLE;
          endcase
        end
      end
      S_RD:    w_next = S_CAP;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_data      <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_err       <= w_ovf_hit | w_unf_hit;
      r_pop_valid <= (r_state == S_CAP);
      if (w_acc) r_data <= bus.op_data;
      if (r_state == S_CAP) r_pop_data <= bus.scr_rdata;
      if (w_ovf_hit) r_ovf <= 1'b1;
      if (w_unf_hit) r_unf <= 1'b1;
      if (r_state == S_CLR) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end
      unique case (r_state)
        S_WR:        r_cnt <= r_cnt + 9'd1;
        S_CAP:       r_cnt <= r_cnt - 9'd1;
        S_LD, S_CLR: r_cnt <= '0;
        default:     r_cnt <= r_cnt;
      endcase
    end
  end

  // Address depends only on state and SP, never on OP_*
  always_comb begin
    w_addr = '0;
    if (r_state == S_WR) w_addr = bus.sp_in - 8'd1;
    if (r_state == S_RD) w_addr = bus.sp_in;
  end

  assign bus.op_ready  = w_idle;
  assign bus.pop_data  = r_pop_data;
  assign bus.pop_valid = r_pop_valid;
  assign bus.sp_data   = r_data[7:0];
  assign bus.sp_rst    = (r_state == S_INIT)
                       | (r_state == S_CLR);
  assign bus.sp_ld     = (r_state == S_LD);
  assign bus.sp_incr   = (r_state == S_CAP);
  assign bus.sp_decr   = (r_state == S_WR);
  assign bus.scr_addr  = w_addr;
  assign bus.scr_we    = (r_state == S_WR);
  assign bus.scr_wdata = r_data;
  assign bus.err       = r_err;
  assign bus.ovf       = r_ovf;
  assign bus.unf       = r_unf;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: SP/RAM models plus a pop-data
// scoreboard fed at request time, drained on POP_VALID.
module tb_stack_ctrl;
  import stack_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  stack_ctrl_if #(.DATA_W(10)) bus ();

  stack_ctrl #(
    .DATA_W(10),
    .STACK_MAX(4)
  ) u_dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus.slave)
  );

  logic [7:0] r_sp;
  logic [9:0] mem [256];
  logic [9:0] ref_q [$];
  logic [9:0] exp_q [$];
  logic [7:0] exp_sp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External SP register and synchronous scratch RAM
  always @(posedge clk) begin
    if (bus.sp_rst)       r_sp <= 8'd0;
    else if (bus.sp_ld)   r_sp <= bus.sp_data;
    else if (bus.sp_incr) r_sp <= r_sp + 8'd1;
    else if (bus.sp_decr) r_sp <= r_sp - 8'd1;
    if (bus.scr_we) mem[bus.scr_addr] <= bus.scr_wdata;
    bus.scr_rdata <= mem[bus.scr_addr];
  end
  assign bus.sp_in = r_sp;

  always @(negedge clk) begin
    if (rst_n && bus.pop_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got=%h", bus.pop_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if (bus.pop_data !== e) begin
          errors++;
          $display("FAIL pop_data got=%h want=%h",
                   bus.pop_data, e);
        end
      end
    end
    checks++;
    if ($countones({bus.sp_rst, bus.sp_ld,
                    bus.sp_incr, bus.sp_decr}) > 1) begin
      errors++;
      $display("FAIL strobe_onehot got=%b want<=1 high",
               {bus.sp_rst, bus.sp_ld,
                bus.sp_incr, bus.sp_decr});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] code,
                       input logic [9:0] data);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_data  = data;
    tick();
    bus.op_valid = 1'b0;
    bus.op_code  = 3'b000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ref_q.delete();
    exp_q.delete();
    exp_sp = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_ok(input logic [9:0] d);
    ref_q.push_back(d);
    issue(OP_PUSH, d);
    exp_sp = exp_sp - 8'd1;
    checks++;
    if (bus.scr_we !== 1'b1 || bus.scr_addr !== exp_sp
        || bus.scr_wdata !== d || bus.sp_decr !== 1'b1
        || bus.op_ready !== 1'b0) begin
      errors++;
      $display("FAIL push_wr got=%b/%h/%h/%b/%b want=1/%h/%h/1/0",
               bus.scr_we, bus.scr_addr, bus.scr_wdata,
               bus.sp_decr, bus.op_ready, exp_sp, d);
    end
    tick();
    checks++;
    if (bus.op_ready !== 1'b1 || r_sp !== exp_sp
        || bus.scr_we !== 1'b0) begin
      errors++;
      $display("FAIL push_done got=%b/%h/%b want=1/%h/0",
               bus.op_ready, r_sp, bus.scr_we, exp_sp);
    end
  endtask

  task automatic pop_ok();
    int k;
    exp_q.push_back(ref_q.pop_back());
    issue(OP_POP, 10'h000);
    k = 1;
    while (!bus.pop_valid && k < 6) begin
      tick();
      k++;
    end
    exp_sp = exp_sp + 8'd1;
    checks++;
    if (k != 3 || bus.op_ready !== 1'b1
        || r_sp !== exp_sp) begin
      errors++;
      $display("FAIL pop_timing got=%0d/%b/%h want=3/1/%h",
               k, bus.op_ready, r_sp, exp_sp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    exp_sp = 8'h00;
    tick();
    tick();
    checks++;
    if (bus.op_ready !== 1'b0 || bus.sp_rst !== 1'b1
        || bus.pop_valid !== 1'b0 || bus.pop_data !== 10'h0
        || bus.err !== 1'b0 || bus.ovf !== 1'b0
        || bus.unf !== 1'b0 || bus.scr_addr !== 8'h00
        || bus.scr_we !== 1'b0 || bus.sp_ld !== 1'b0
        || bus.sp_incr !== 1'b0 || bus.sp_decr !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals rdy=%b rst=%b pv=%b err=%b",
               bus.op_ready, bus.sp_rst, bus.pop_valid, bus.err);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.op_ready !== 1'b0 || bus.sp_rst !== 1'b1) begin
      errors++;
      $display("FAIL init_cycle got=%b/%b want=0/1",
               bus.op_ready, bus.sp_rst);
    end
    tick();
    checks++;
    if (bus.op_ready !== 1'b1 || bus.sp_rst !== 1'b0
        || r_sp !== 8'h00) begin
      errors++;
      $display("FAIL idle_after_init got=%b/%b/%h want=1/0/00",
               bus.op_ready, bus.sp_rst, r_sp);
    end
  endtask

  task automatic test_push_basic();
    do_reset();
    push_ok(10'h155);
    checks++;
    if (mem[8'hFF] !== 10'h155) begin
      errors++;
      $display("FAIL ram_ff got=%h want=155", mem[8'hFF]);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    push_ok(10'h0A1);
    push_ok(10'h0B2);
    pop_ok();
    pop_ok();
    checks++;
    if (r_sp !== 8'h00) begin
      errors++;
      $display("FAIL sp_back got=%h want=00", r_sp);
    end
    // CNT must be 0 again, so one more POP underflows
    issue(OP_POP, 10'h000);
    checks++;
    if (bus.err !== 1'b1 || bus.unf !== 1'b1) begin
      errors++;
      $display("FAIL cnt_zero got=%b/%b want=1/1",
               bus.err, bus.unf);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    issue(OP_POP, 10'h000);
    checks++;
    if (bus.err !== 1'b1 || bus.unf !== 1'b1
        || bus.op_ready !== 1'b1 || bus.sp_incr !== 1'b0) begin
      errors++;
      $display("FAIL unf_hit got=%b/%b/%b/%b want=1/1/1/0",
               bus.err, bus.unf, bus.op_ready, bus.sp_incr);
    end
    tick();
    checks++;
    if (bus.err !== 1'b0 || bus.unf !== 1'b1
        || bus.sp_incr !== 1'b0 || r_sp !== 8'h00) begin
      errors++;
      $display("FAIL unf_sticky got=%b/%b/%b/%h want=0/1/0/00",
               bus.err, bus.unf, bus.sp_incr, r_sp);
    end
    issue(OP_CLR, 10'h000);
    checks++;
    if (bus.sp_rst !== 1'b1 || bus.op_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_act got=%b/%b want=1/0",
               bus.sp_rst, bus.op_ready);
    end
    tick();
    checks++;
    if (bus.unf !== 1'b0 || bus.op_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_done got=%b/%b want=0/1",
               bus.unf, bus.op_ready);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) push_ok(10'(10'h100 + i));
    issue(OP_PUSH, 10'h3C3);
    checks++;
    if (bus.err !== 1'b1 || bus.ovf !== 1'b1
        || bus.scr_we !== 1'b0 || bus.sp_decr !== 1'b0
        || bus.op_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovf_hit got=%b/%b/%b/%b/%b want=1/1/0/0/1",
               bus.err, bus.ovf, bus.scr_we,
               bus.sp_decr, bus.op_ready);
    end
    issue(OP_PUSH, 10'h3C4);
    checks++;
    if (bus.err !== 1'b1 || bus.scr_we !== 1'b0) begin
      errors++;
      $display("FAIL ovf_b2b got=%b/%b want=1/0",
               bus.err, bus.scr_we);
    end
    tick();
    checks++;
    if (bus.err !== 1'b0 || bus.ovf !== 1'b1
        || r_sp !== exp_sp) begin
      errors++;
      $display("FAIL ovf_sticky got=%b/%b/%h want=0/1/%h",
               bus.err, bus.ovf, r_sp, exp_sp);
    end
    for (int i = 0; i < 4; i++) pop_ok();
    issue(3'b101, 10'h3FF);
    checks++;
    if (bus.op_ready !== 1'b1 || bus.err !== 1'b0
        || bus.scr_we !== 1'b0 || bus.sp_ld !== 1'b0) begin
      errors++;
      $display("FAIL nop_101 got=%b/%b/%b/%b want=1/0/0/0",
               bus.op_ready, bus.err, bus.scr_we, bus.sp_ld);
    end
  endtask

  task automatic test_ldsp();
    do_reset();
    issue(OP_LDSP, 10'h280);
    checks++;
    if (bus.sp_ld !== 1'b1 || bus.sp_data !== 8'h80
        || bus.op_ready !== 1'b0) begin
      errors++;
      $display("FAIL ldsp_act got=%b/%h/%b want=1/80/0",
               bus.sp_ld, bus.sp_data, bus.op_ready);
    end
    tick();
    exp_sp = 8'h80;
    checks++;
    if (r_sp !== 8'h80 || bus.op_ready !== 1'b1) begin
      errors++;
      $display("FAIL ldsp_done got=%h/%b want=80/1",
               r_sp, bus.op_ready);
    end
    push_ok(10'h3FF);
    checks++;
    if (mem[8'h7F] !== 10'h3FF) begin
      errors++;
      $display("FAIL ram_7f got=%h want=3ff", mem[8'h7F]);
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    push_ok(10'h2AA);
    exp_q.push_back(ref_q.pop_back());
    issue(OP_POP, 10'h000);
    tick();
    checks++;
    if (bus.sp_incr !== 1'b1) begin
      errors++;
      $display("FAIL cap_state got=%b want=1", bus.sp_incr);
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (bus.sp_incr !== 1'b0 || bus.sp_rst !== 1'b1
        || bus.op_ready !== 1'b0 || bus.pop_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_cap got=%b/%b/%b/%b want=0/1/0/0",
               bus.sp_incr, bus.sp_rst,
               bus.op_ready, bus.pop_valid);
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.sp_rst !== 1'b1 || bus.op_ready !== 1'b0
        || bus.pop_valid !== 1'b0 || bus.pop_data !== 10'h0
        || bus.scr_addr !== 8'h00) begin
      errors++;
      $display("FAIL abort_init got=%b/%b/%b/%h want=1/0/0/000",
               bus.sp_rst, bus.op_ready,
               bus.pop_valid, bus.pop_data);
    end
    tick();
    exp_sp = 8'h00;
    checks++;
    if (bus.op_ready !== 1'b1 || r_sp !== 8'h00) begin
      errors++;
      $display("FAIL abort_idle got=%b/%h want=1/00",
               bus.op_ready, r_sp);
    end
    issue(OP_PUSH, 10'h011);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.scr_we !== 1'b0 || bus.sp_decr !== 1'b0) begin
      errors++;
      $display("FAIL abort_wr got=%b/%b want=0/0",
               bus.scr_we, bus.sp_decr);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    bus.op_valid = 1'b0;
    bus.op_code  = 3'b000;
    bus.op_data  = 10'h000;
    for (int i = 0; i < 256; i++) mem[i] = 10'h000;
    test_reset();
    test_push_basic();
    test_push_pop();
    test_underflow();
    test_back_to_back();
    test_ldsp();
    test_reset_abort();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pops_missing got=%0d want=0",
               exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Sequencer for the MCU's hardware stack. Accepts one stack operation at a time (PUSH, POP, LDSP, CLR) over a valid/ready handshake, drives the stack-pointer register's control strobes (SP_RST, SP_LD, SP_INCR, SP_DECR), and issues the matching scratch-RAM write or read. Tracks stack occupancy and rejects overflowing or underflowing operations with sticky error flags. Sits between the control unit and the SP/scratch-RAM pair.

## Interface
- DATA_W, 10: width of stacked data (scratch-RAM word).
- STACK_MAX, 256: maximum occupancy; a PUSH at this count overflows.
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- OP_VALID  in  1  operation request.
- OP_CODE  in  3  000 NOP, 001 PUSH, 010 POP, 011 LDSP, 100 CLR; 101–111 treated as NOP.
- OP_DATA  in  DATA_W  PUSH data; LDSP uses [7:0].
- OP_READY  out  1  controller can accept an operation.
- POP_DATA  out  DATA_W  registered POP result.
- POP_VALID  out  1  one-cycle pulse, POP_DATA valid.
- SP_IN  in  8  current stack-pointer value.
- SP_DATA  out  8  load value to SP.
- SP_RST, SP_LD, SP_INCR, SP_DECR  out  1 each  SP control strobes, at most one high per cycle.
- SCR_ADDR  out  8  scratch-RAM address.
- SCR_WE  out  1  scratch-RAM write enable.
- SCR_WDATA  out  DATA_W  scratch-RAM write data.
- SCR_RDATA  in  DATA_W  scratch-RAM read data, synchronous read, 1-cycle latency.
- ERR  out  1  one-cycle pulse on a rejected operation.
- OVF, UNF  out  1 each  sticky overflow/underflow flags; cleared by reset or CLR.

## Operation
- The stack grows down. PUSH writes to SP_IN−1 and decrements SP. POP reads at SP_IN and increments SP. All address arithmetic is 8-bit modulo: a PUSH at SP=0x00 writes address 0xFF.
- CNT is a 9-bit internal occupancy counter, range 0..STACK_MAX: +1 per PUSH, −1 per POP, 0 on LDSP/CLR.
- FSM states:
  - INIT: SP_RST=1, OP_READY=0. Always followed by IDLE.
  - IDLE: OP_READY=1. On OP_VALID&&OP_READY, latch OP_CODE and OP_DATA, then branch:
    - PUSH with CNT==STACK_MAX: ERR pulse next cycle, OVF set, no SP or RAM activity, stay IDLE.
    - PUSH otherwise: go to WR.
    - POP with CNT==0: ERR pulse next cycle, UNF set, no activity, stay IDLE.
    - POP otherwise: go to RD.
    - LDSP: go to LD.
    - CLR: go to CLR.
    - NOP: stay IDLE.
  - WR: SCR_ADDR=SP_IN−1, SCR_WDATA=latched data, SCR_WE=1, SP_DECR=1, CNT+1. Next IDLE.
  - RD: SCR_ADDR=SP_IN. Next CAP.
  - CAP: POP_DATA<=SCR_RDATA, SP_INCR=1, CNT−1, POP_VALID high next cycle. Next IDLE.
  - LD: SP_LD=1, SP_DATA=latched OP_DATA[7:0], CNT<=0. Next IDLE.
  - CLR: SP_RST=1, CNT<=0, OVF/UNF cleared. Next IDLE.
- OP_READY is low in every non-IDLE state. OP_VALID is ignored while OP_READY=0.

## Timing
- Reset values: state=INIT, all strobes 0 except SP_RST=1 (INIT), OP_READY=0, POP_DATA=0, POP_VALID=0, ERR=0, OVF=UNF=0, CNT=0, SCR_ADDR=0. The first cycle after RST_N rises is INIT; OP_READY rises the cycle after that.
- Accept cycle T in IDLE:
  - PUSH: WR at T+1; SP and RAM updated at the T+1 edge; OP_READY high at T+2.
  - POP: RD at T+1, CAP at T+2; POP_VALID and POP_DATA at T+3, SP updated at T+3, OP_READY high at T+3.
  - LDSP/CLR: action at T+1, OP_READY high at T+2.
  - Rejected op: ERR at T+1, OP_READY stays high, so back-to-back requests are allowed.
- Strobes, SCR_WE, and SCR_ADDR are Moore outputs of the state, free of combinational paths from OP_*.
- RST_N asserted mid-operation aborts immediately; a partially issued write is not completed (SCR_WE drops asynchronously).

## Structure
- Package stack_pkg: op_e (NOP/PUSH/POP/LDSP/CLR encodings), state_e (INIT, IDLE, WR, RD, CAP, LD, CLR), default DATA_W.
- Single module with no sub-modules. The SP register and scratch RAM remain external instances wired at the MCU top level.

## Test plan
- Reset, then PUSH 0x155 at SP=0x00 -> SCR_WE with SCR_ADDR=0xFF and SCR_WDATA=0x155 at T+1; SP_DECR pulse; OP_READY low for 1 cycle.
- PUSH 0x0A1, PUSH 0x0B2, POP, POP -> POP_DATA 0x0B2 then 0x0A1, each with a POP_VALID pulse at T+3; SP returns to 0x00; CNT ends at 0.
- POP immediately after reset -> ERR pulse, UNF=1, no SP_INCR and no RAM read; subsequent CLR -> UNF=0 and SP_RST pulse.
- STACK_MAX=4: five PUSHes -> the fifth raises ERR and OVF, with no SCR_WE or SP_DECR on that attempt.
- LDSP 0x80 then PUSH 0x3FF -> SP_LD with SP_DATA=0x80, then write at address 0x7F.
- Assert RST_N low during CAP of a POP -> no POP_VALID, state INIT after release, SP_RST pulse, outputs at reset values.
